pc_unit_ras: RTL

//   Next-generation program-counter register for the pipelined core. Holds the fetch
//   PC, advances it by a configurable step, and redirects it on trap, return, call,

---
 rtl/pc_unit_ras.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: fetch program counter with an internal circular return-address stack.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   enable                        1 = PC may advance/redirect, 0 = stall
//   trap                          redirect to TRAP_VEC and flush RAS (ignores enable)
//   ret                           pop RAS, redirect to popped address
//   call, jump, jump_address      redirect to jump_address (call also pushes pc_out+STEP)
//   branch_taken, branch_target   redirect to branch_target
//   pc_out                        current fetch PC (registered)
//   ras_empty, ras_full           RAS occupancy, decoded from the entry count
//   ras_overflow                  sticky: a push landed on a full RAS
//   ras_underflow                 one-cycle pulse after a ret on an empty RAS
module pc_unit_ras #(
   parameter int unsigned   N         = 32,
   parameter int unsigned   STEP      = 1,
   parameter logic [N-1:0]  RESET_PC  = '0,
   parameter logic [N-1:0]  TRAP_VEC  = '0,
   parameter int unsigned   RAS_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         trap,
   input  logic         ret,
   input  logic         call,
   input  logic         jump,
   input  logic [N-1:0] jump_address,
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   output logic [N-1:0] pc_out,
   output logic         ras_empty,
   output logic         ras_full,
   output logic         ras_overflow,
   output logic         ras_underflow
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [N-1:0]  r_pc;
   logic [N-1:0]  r_stack [RAS_DEPTH];
   logic [PW-1:0] r_ptr;   // next free slot; top of stack is r_ptr-1
   logic [CW-1:0] r_cnt;
   logic          r_ovf;
   logic          r_unf;

   logic [N-1:0]  w_pc_inc;
   logic [N-1:0]  w_top;
   logic          w_empty;
   logic          w_full;
   logic [N-1:0]  w_pc_nxt;
   logic [PW-1:0] w_ptr_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_push;
   logic          w_ovf_set;
   logic          w_unf_nxt;

   assign w_pc_inc = r_pc + N'(STEP);
   assign w_top    = r_stack[r_ptr - PW'(1)];
   assign w_empty  = (r_cnt == CW'(0));
   assign w_full   = (r_cnt == CW'(RAS_DEPTH));

   // Next-PC / RAS update selection, highest priority first
   always_comb begin
      w_pc_nxt  = r_pc;
      w_ptr_nxt = r_ptr;
      w_cnt_nxt = r_cnt;
      w_push    = 1'b0;
      w_ovf_set = 1'b0;
      w_unf_nxt = 1'b0;
      if (trap) begin
         w_pc_nxt  = TRAP_VEC;
         w_cnt_nxt = CW'(0);
      end else if (enable) begin
         if (ret) begin
            if (w_empty) begin
               w_pc_nxt  = w_pc_inc;
               w_unf_nxt = 1'b1;
            end else begin
               w_pc_nxt  = w_top;
               w_ptr_nxt = r_ptr - PW'(1);
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end else if (call) begin
            w_pc_nxt  = jump_address;
            w_push    = 1'b1;
            w_ptr_nxt = r_ptr + PW'(1);
            // Full stack: the slot at r_ptr holds the oldest entry and is overwritten
            if (w_full) w_ovf_set = 1'b1;
            else        w_cnt_nxt = r_cnt + CW'(1);
         end else if (jump) begin
            w_pc_nxt = jump_address;
         end else if (branch_taken) begin
            w_pc_nxt = branch_target;
         end else begin
            w_pc_nxt = w_pc_inc;
         end
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc  <= RESET_PC;
         r_ptr <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_pc  <= w_pc_nxt;
         r_ptr <= w_ptr_nxt;
         r_cnt <= w_cnt_nxt;
         r_ovf <= r_ovf | w_ovf_set;
         r_unf <= w_unf_nxt;
      end
   end

   // Stack storage, contents are not reset
   always_ff @(posedge clk) begin
      if (!rst && w_push) r_stack[r_ptr] <= w_pc_inc;
   end

   assign pc_out        = r_pc;
   assign ras_empty     = w_empty;
   assign ras_full      = w_full;
   assign ras_overflow  = r_ovf;
   assign ras_underflow = r_unf;

endmodule
